// File: rtl/sequence_sender.sv
// sequence_sender: serialises a captured payload as header, per-stream
// sequence number and big-endian data words over a valid/ready output.
//
// Ports:
//   clk, reset_b          clock, async active-low reset
//   dataIn[0:295]         37-byte payload, byte k = bits [8k:8k+7]
//   dataIn_len            payload byte count, legal 1..37
//   dataIn_stream         stream ID, bits [4:0] select the sequence counter
//   dataIn_val/ready      payload handshake (ready only while idle)
//   dataOut               32-bit output word, byte 0 in bits [31:24]
//   dataOut_val/ready     output handshake
//   dataOut_last          final word of the packet
//   badLen                one-cycle pulse when an illegal length is dropped
module sequence_sender (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [0:295] dataIn,
    input  logic [5:0]   dataIn_len,
    input  logic [15:0]  dataIn_stream,
    input  logic         dataIn_val,
    output logic         dataIn_ready,
    output logic [31:0]  dataOut,
    output logic         dataOut_val,
    input  logic         dataOut_ready,
    output logic         dataOut_last,
    output logic         badLen
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND_HDR  = 2'd1;
    localparam logic [1:0] SEND_SEQ  = 2'd2;
    localparam logic [1:0] SEND_DATA = 2'd3;

    logic [1:0]   r_state;
    logic         r_rdy;
    logic         r_badlen;
    logic [319:0] r_buf;
    logic [5:0]   r_rem;
    logic [5:0]   r_len;
    logic [15:0]  r_stream;
    logic [31:0]  r_seq;
    logic [31:0]  r_cnt [32];

    logic         w_in_fire;
    logic         w_len_ok;
    logic         w_out_fire;
    logic         w_last;
    logic [31:0]  w_seq_cur;
    logic [31:0]  w_seq_nxt;
    logic [31:0]  w_data;
    logic [15:0]  w_hdr_len;

    // r_rdy keeps dataIn_ready low during reset and raises it on the
    // first edge after release; it never depends on dataOut_ready.
    assign dataIn_ready = r_rdy && (r_state == IDLE);
    assign w_in_fire    = dataIn_val && dataIn_ready;
    assign w_len_ok     = (dataIn_len != 6'd0) && (dataIn_len <= 6'd37);
    assign w_out_fire   = dataOut_val && dataOut_ready;

    // Counter read/increment for the stream currently presented.
    assign w_seq_cur    = r_cnt[dataIn_stream[4:0]];
    assign w_seq_nxt    = w_seq_cur + 32'd1;

    // r_rem is the number of payload bytes not yet sent; the current
    // word is always the top 32 bits of r_buf.
    assign w_last       = (r_rem <= 6'd4);
    assign w_hdr_len    = {10'd0, r_len} + 16'd8;

    assign w_data = {
        r_buf[319:312],
        (r_rem > 6'd1) ? r_buf[311:304] : 8'h00,
        (r_rem > 6'd2) ? r_buf[303:296] : 8'h00,
        (r_rem > 6'd3) ? r_buf[295:288] : 8'h00
    };

    always_comb begin
        dataOut      = 32'd0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        case (r_state)
            SEND_HDR: begin
                dataOut     = {w_hdr_len, r_stream};
                dataOut_val = 1'b1;
            end
            SEND_SEQ: begin
                dataOut     = r_seq;
                dataOut_val = 1'b1;
            end
            SEND_DATA: begin
                dataOut      = w_data;
                dataOut_val  = 1'b1;
                dataOut_last = w_last;
            end
            default: ;
        endcase
    end

    assign badLen = r_badlen;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state  <= IDLE;
            r_rdy    <= 1'b0;
            r_badlen <= 1'b0;
            r_buf    <= '0;
            r_rem    <= '0;
            r_len    <= '0;
            r_stream <= '0;
            r_seq    <= '0;
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_rdy    <= 1'b1;
            r_badlen <= w_in_fire && !w_len_ok;
            case (r_state)
                IDLE: begin
                    if (w_in_fire && w_len_ok) begin
                        r_buf    <= {dataIn, 24'h0};
                        r_rem    <= dataIn_len;
                        r_len    <= dataIn_len;
                        r_stream <= dataIn_stream;
                        r_seq    <= w_seq_nxt;
                        r_cnt[dataIn_stream[4:0]] <= w_seq_nxt;
                        r_state  <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    if (w_out_fire) begin
                        r_state <= SEND_SEQ;
                    end
                end
                SEND_SEQ: begin
                    if (w_out_fire) begin
                        r_state <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (w_out_fire) begin
                        if (w_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_buf <= r_buf << 32;
                            r_rem <= r_rem - 6'd4;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sequence_sender.md
SEQUENCE_SENDER -- requirements
Module: sequence_sender

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_b  input  1  reset, asynchronous and active-low.
REQ-004 dataIn  input  [0:295]  payload, 37 bytes; byte k = bits [8k:8k+7], byte 0 sent first.
REQ-005 dataIn_len  input  6  payload byte count; valid range 1..37.
REQ-006 dataIn_stream  input  16  stream ID.
REQ-007 dataIn_val  input  1  payload request valid.
REQ-008 dataIn_ready  output  1  block can accept a payload.
REQ-009 dataOut  output  32  serialized word; byte 0 of the word is bits [31:24].
REQ-010 dataOut_val  output  1  dataOut valid.
REQ-011 dataOut_ready  input  1  downstream accepts the word.
REQ-012 dataOut_last  output  1  marks the final word of a packet.
REQ-013 badLen  output  1  one-cycle pulse; a payload with illegal dataIn_len was dropped.

Function
REQ-014 A payload handshake SHALL occur on a cycle with dataIn_val && dataIn_ready; dataIn, dataIn_len and dataIn_stream are captured on that edge.
REQ-015 The FSM SHALL use the states IDLE, SEND_HDR, SEND_SEQ and SEND_DATA; dataIn_ready SHALL be 1 only in IDLE.
REQ-016 IDLE -> SEND_HDR on a handshake with a legal length; an illegal length (0 or >37) keeps IDLE, pulses badLen next cycle, and produces no output words and no sequence update.
REQ-017 The header word SHALL be {len+8 [15:0], dataIn_stream}; the length includes the 8 header/sequence bytes.
REQ-018 The sequence word SHALL be seqs[stream[4:0]]+1, 32-bit modulo (0xFFFFFFFF+1 = 0).
REQ-019 The block SHALL hold 32 sequence counters, indexed by stream[4:0]; streams differing only in bits [15:5] share a counter.
REQ-020 The counter SHALL be written with the new value at the capture edge, so back-to-back packets on one stream get consecutive numbers.
REQ-021 SEND_HDR -> SEND_SEQ, SEND_SEQ -> SEND_DATA and data word advance SHALL occur only on a dataOut_val && dataOut_ready edge.
REQ-022 SEND_DATA SHALL emit ceil(len/4) words (1..10); word i carries payload bytes 4i..4i+3.
REQ-023 In the final word, bytes beyond len SHALL be driven 0, and dataOut_last SHALL be 1 only on that word.
REQ-024 On a handshake of the last word, the FSM SHALL return to IDLE, with dataIn_ready = 1 on the following cycle.
REQ-025 dataOut_val SHALL be 1 in SEND_HDR, SEND_SEQ and SEND_DATA, and 0 in IDLE.
REQ-026 While dataOut_val && !dataOut_ready, dataOut and dataOut_last SHALL remain stable.
REQ-027 Latency SHALL be: payload handshake at edge N -> header valid after edge N; no bubbles between words when dataOut_ready stays 1.
REQ-028 dataIn_val and dataIn_ready SHALL NOT be combinationally dependent on dataOut_ready.

Reset
REQ-029 While reset_b = 0, the block SHALL be in IDLE with dataOut_val = 0, dataOut_last = 0, dataOut = 0, badLen = 0, dataIn_ready = 0, all 32 counters = 0, and captured payload = 0.
REQ-030 Assertion of reset_b mid-packet SHALL abort the packet immediately (asynchronously) with no further words emitted; the first sequence after release per stream SHALL be 1.
REQ-031 After reset_b deasserts, dataIn_ready SHALL be 1 from the first clock edge.

Verification
REQ-032 Stream 0x0003, len 5, bytes 01..05, dataOut_ready = 1 -> emitted words 0x000D0003, 0x00000001, 0x01020304, then 0x05000000 with last = 1; 4 consecutive valid cycles.
REQ-033 Two packets on stream 0x0023 then one on stream 0x0003, len 4 each -> sequence words 1, 2, 3 (shared counter); last on the third word of each packet.
REQ-034 len 37, dataOut_ready toggling 1,0,0,1,... -> 12 words total; the 10th data word = {byte36, 24'h0} with last = 1; each word holds stable while stalled.
REQ-035 len 0, then len 40 -> badLen pulses twice, no dataOut_val; the next legal packet on stream 0 has sequence 1.
REQ-036 Counter for stream 7 preloaded to 0xFFFFFFFF via 0xFFFFFFFF packets -> next sequence word 0x00000000 (use force or shortened test hook).
REQ-037 Reset asserted during the 3rd data word of a 10-word packet -> dataOut_val = 0 immediately; after release, a packet on the same stream carries sequence 1.
